mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-port, variable-latency backing memory between the IF-stage instruction fetch and the MEM-stage data access of the 64-bit pipelined CPU. It arbitrates requests and runs a three-state transaction FSM. It returns read data with a one-cycle acknowledge pulse and drives per-stage stall signals to hold the pipeline while a requester waits. Data accesses have priority; an optional starvation guard bounds fetch latency.

## Interface
Parameters:
- ADDR_W, 64, width of all address buses
- STARVE_MAX, 4, consecutive lost arbitrations before a pending fetch is forced through (guard build only)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, held high until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse, if_instr valid
- if_instr  out  32  fetched instruction (ram_rdata[31:0])
- mem_req  in  1  data request, held high until mem_ack
- mem_we  in  1  1 = store, 0 = load
- mem_addr  in  ADDR_W  data address
- mem_wdata  in  64  store data
- mem_ack  out  1  one-cycle pulse, access complete / mem_rdata valid
- mem_rdata  out  64  load data
- ram_req  out  1  one-cycle start pulse to backing memory
- ram_we  out  1  write enable, qualified by ram_req
- ram_addr  out  ADDR_W  latched address
- ram_wdata  out  64  latched store data
- ram_rvalid  in  1  completion for reads and writes, earliest one cycle after ram_req
- ram_rdata  in  64  read data, valid with ram_rvalid
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  mem_req & ~mem_ack

## Operation
- States: ARB_IDLE, ARB_BUSY, ARB_RESP. The owner register (INST/DATA) is set on grant.
- ARB_IDLE: if mem_req, grant DATA; else if if_req, grant INST; else stay. On grant, latch the address, ram_we (mem_we for DATA, 0 for INST) and wdata, and go to ARB_BUSY.
- ARB_BUSY: ram_req is high only in the first BUSY cycle, so it is exactly one pulse per transaction. Stay until ram_rvalid. On ram_rvalid, capture ram_rdata into if_instr or mem_rdata per owner, and go to ARB_RESP.
- ARB_RESP: pulse the owner's ack for one cycle, then return to ARB_IDLE. No arbitration happens in RESP, so a still-asserted req is never re-granted.
- Only one transaction is ever outstanding. if_ack and mem_ack are never high together.
- ram_rvalid in IDLE or RESP is ignored, including a stale completion after reset.
- A requester dropping req mid-transaction does not abort it: the transaction completes and ack is still pulsed.
- Stores return mem_ack with mem_rdata unchanged.
- Reset (any state): state ARB_IDLE, owner INST, and all outputs 0: ram_req, ram_we, ram_addr, ram_wdata, if_ack, mem_ack, if_instr, mem_rdata. The starvation counter is 0. stall_* then follow the req inputs.

## Timing
- Grant in IDLE cycle N; ram_req at N+1; earliest ram_rvalid at N+2; ack at N+3. Minimum latency is 3 cycles, plus RAM latency beyond 1.
- Back-to-back: the next grant is possible in the IDLE cycle at N+4. Peak throughput is 1 transaction per 4 cycles with single-cycle RAM.
- if_ack, mem_ack, ram_* and the data outputs are registered. stall_* are combinational from req inputs and registered acks.

## Configuration
- ARB_STARVE_GUARD_EN defined: a counter of width $clog2(STARVE_MAX+1) tracks fetch starvation.
  - It increments on each IDLE grant to DATA while if_req is high.
  - It clears on an INST grant or whenever if_req is low.
  - When it equals STARVE_MAX, the next IDLE arbitration grants INST even if mem_req is high.
- ARB_STARVE_GUARD_EN undefined: strict data priority, and there is no counter logic.

## Structure
- Package cpu_mem_pkg holds:
  - the arb_state_t enum (ARB_IDLE, ARB_BUSY, ARB_RESP)
  - the arb_owner_t enum (OWN_INST, OWN_DATA)
  - INSTR_W=32 and DATA_W=64 constants
- Sub-module arb_starve_cnt (parameter STARVE_MAX) holds the starvation counter. It is instantiated only under ARB_STARVE_GUARD_EN.

## Test plan
- **Fetch only:** if_req=1, if_addr=0x10; RAM returns 0x00000000_8B020041 one cycle after ram_req.
  - Required: ram_req 1 cycle after grant, ram_we=0, ram_addr=0x10.
  - Required: if_ack pulse 3 cycles after grant with if_instr=0x8B020041, stall_if high until then.
- **Collision:** if_req and mem_req (load, addr 0x40) rise together.
  - Required: DATA served first, mem_ack before if_ack, fetch granted in the IDLE cycle after mem_ack.
- **Store with 3-cycle RAM latency:** mem_we=1, mem_wdata=0xDEADBEEF.
  - Required: ram_we=1, ram_wdata latched.
  - Required: mem_ack exactly 1 cycle after ram_rvalid, stall_mem high for the whole wait.
- **Starvation (guard on, STARVE_MAX=4):** mem_req held continuously with if_req high.
  - Required: the 5th grant is INST, and the counter returns to 0.
  - Guard off: INST is never granted while mem_req stays high.
- **Reset during ARB_BUSY, late completion:** assert reset during BUSY, then deliver ram_rvalid after reset.
  - Required: all outputs 0 and state IDLE the cycle after reset.
  - Required: the stray ram_rvalid produces no ack.
- **Dropped request:** drop if_req during BUSY.
  - Required: the transaction completes, if_ack still pulses once, and no second ram_req is issued.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | cpu_mem_pkg                                                        |
// | Shared types and widths for the memory port arbiter.               |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package cpu_mem_pkg;

  localparam int INSTR_W = 32;
  localparam int DATA_W  = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/arb_starve_cnt.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_starve_cnt                                                     |
// | Counts consecutive arbitrations a pending fetch has lost to data   |
// | accesses; flags when the fetch must be forced through.             |
// | Only present when ARB_STARVE_GUARD_EN is defined.                  |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
`ifdef ARB_STARVE_GUARD_EN
module arb_starve_cnt #(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic grant_inst,
  input  logic grant_data,
  output logic starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] count;

  // Lost-arbitration counter; cleared whenever no fetch is waiting or one is served.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!if_req || grant_inst) begin
      count <= '0;
    end else if (grant_data && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  assign starved = (count == CNT_MAX);

endmodule
`endif
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arbiter                                                   |
// | Shares one single-port variable-latency memory between instruction|
// | fetch and data access. Data has priority; defining                 |
// | ARB_STARVE_GUARD_EN bounds how long a fetch can be starved.        |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ack,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               mem_req,
  input  logic               mem_we,
  input  logic [ADDR_W-1:0]  mem_addr,
  input  logic [DATA_W-1:0]  mem_wdata,
  output logic               mem_ack,
  output logic [DATA_W-1:0]  mem_rdata,
  output logic               ram_req,
  output logic               ram_we,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_wdata,
  input  logic               ram_rvalid,
  input  logic [DATA_W-1:0]  ram_rdata,
  output logic               stall_if,
  output logic               stall_mem
);

  arb_state_t state, state_next;
  arb_owner_t owner;
  logic       grant_inst;
  logic       grant_data;
  logic       force_inst;

  if (STARVE_MAX < 1) begin : g_bad_starve_max
    $error("STARVE_MAX must be at least 1");
  end

`ifdef ARB_STARVE_GUARD_EN
  arb_starve_cnt #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .grant_inst (grant_inst),
    .grant_data (grant_data),
    .starved    (force_inst)
  );
`else
  assign force_inst = 1'b0;
`endif

  // Arbitration only in IDLE; BUSY waits for the memory, RESP is the ack cycle.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    state_next = state;
    case (state)
      ARB_IDLE: begin
        if (if_req && (force_inst || !mem_req)) begin
          grant_inst = 1'b1;
        end else if (mem_req) begin
          grant_data = 1'b1;
        end
        if (grant_inst || grant_data) begin
          state_next = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (ram_rvalid) begin
          state_next = ARB_RESP;
        end
      end
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Transaction state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ARB_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Registered memory command, captured read data and single-cycle acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      owner     <= OWN_INST;
      ram_req   <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_instr  <= '0;
      mem_rdata <= '0;
    end else begin
      // A grant leads directly into the first BUSY cycle, giving one pulse.
      ram_req <= grant_inst || grant_data;
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      if (grant_data) begin
        owner     <= OWN_DATA;
        ram_we    <= mem_we;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
      end else if (grant_inst) begin
        owner    <= OWN_INST;
        ram_we   <= 1'b0;
        ram_addr <= if_addr;
      end
      if ((state == ARB_BUSY) && ram_rvalid) begin
        if (owner == OWN_INST) begin
          if_instr <= ram_rdata[INSTR_W-1:0];
          if_ack   <= 1'b1;
        end else begin
          // Stores complete without disturbing the last load value.
          if (!ram_we) begin
            mem_rdata <= ram_rdata;
          end
          mem_ack <= 1'b1;
        end
      end
    end
  end

  assign stall_if  = if_req  & ~if_ack;
  assign stall_mem = mem_req & ~mem_ack;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arbiter                                                |
// | Self-checking bench for mem_port_arbiter with a transaction-level  |
// | reference model. Expectations adapt to ARB_STARVE_GUARD_EN.        |
// | Revision: 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 64;
  localparam int STARVE_MAX = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              if_req = 1'b0;
  logic [ADDR_W-1:0] if_addr = '0;
  logic              if_ack;
  logic [31:0]       if_instr;
  logic              mem_req = 1'b0;
  logic              mem_we = 1'b0;
  logic [ADDR_W-1:0] mem_addr = '0;
  logic [63:0]       mem_wdata = '0;
  logic              mem_ack;
  logic [63:0]       mem_rdata;
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [63:0]       ram_wdata;
  logic              ram_rvalid = 1'b0;
  logic [63:0]       ram_rdata = '0;
  logic              stall_if;
  logic              stall_mem;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] req_v);
    checks++;
    if (act_v !== req_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act_v, req_v);
    end
  endtask

  // ---------------- reference model (cycle-stamped transactions) ----------------
  int          cyc = 0;
  bit          started = 1'b0;
  bit          t_active = 1'b0;
  int          t_grant = -100;
  int          t_done = -1;
  bit          t_data = 1'b0;
  bit          t_we = 1'b0;
  logic [63:0] m_addr = '0;
  logic [63:0] m_wdata = '0;
  bit          m_we = 1'b0;
  logic [31:0] m_if_instr = '0;
  logic [63:0] m_mem_rdata = '0;
  int          lost = 0;
  int          lat = 1;
  logic [63:0] rd_val = '0;
  int          stray_cyc = -1;

  // Model update at each edge: record completion, then arbitrate if the port is free.
  always @(posedge clk) begin
    if (reset) begin
      started = 1'b1; t_active = 1'b0; t_done = -1; t_grant = -100;
      m_addr = '0; m_wdata = '0; m_we = 1'b0;
      m_if_instr = '0; m_mem_rdata = '0; lost = 0;
    end else if (started) begin
      if (t_active && t_done < 0 && cyc > t_grant && ram_rvalid) begin
        t_done = cyc;
        if (!t_data) m_if_instr = ram_rdata[31:0];
        else if (!t_we) m_mem_rdata = ram_rdata;
      end
      if (!t_active || (t_done >= 0 && cyc >= t_done + 2)) begin
        t_active = 1'b0;
        if (if_req && (!mem_req || (GUARD && lost == STARVE_MAX))) begin
          t_active = 1'b1; t_grant = cyc; t_done = -1; t_data = 1'b0; t_we = 1'b0;
          m_addr = if_addr; m_we = 1'b0; lost = 0;
        end else if (mem_req) begin
          t_active = 1'b1; t_grant = cyc; t_done = -1; t_data = 1'b1; t_we = mem_we;
          m_addr = mem_addr; m_we = mem_we; m_wdata = mem_wdata;
          if (if_req) lost++;
        end
      end
      if (!if_req) lost = 0;
    end
    cyc++;
  end

  // Memory responder: completes model transactions after `lat` cycles, plus optional stray pulse.
  always @(posedge clk) begin
    #2;
    ram_rvalid = (t_active && t_done < 0 && cyc == t_grant + 1 + lat) || (cyc == stray_cyc);
    ram_rdata  = ram_rvalid ? rd_val : 64'hFFFF_0000_FFFF_0000;
  end

  // ---------------- compare process and event stamps ----------------
  int          n_if_ack = 0;
  int          n_mem_ack = 0;
  int          last_if_ack = -1;
  int          last_mem_ack = -1;
  int          last_rvalid = -1;
  int          last_rr_cyc = -1;
  logic [63:0] last_rr_addr = '0;
  logic [63:0] last_rr_wdata = '0;
  logic        last_rr_we = 1'b0;
  logic [63:0] rr_addr[$];

  // Every cycle after reset, compare all outputs with the model.
  always @(negedge clk) begin
    if (started) begin
      chk("ram_req",   ram_req,   t_active && cyc == t_grant + 1);
      chk("ram_we",    ram_we,    m_we);
      chk("ram_addr",  ram_addr,  m_addr);
      chk("ram_wdata", ram_wdata, m_wdata);
      chk("if_ack",    if_ack,    t_active && !t_data && t_done >= 0 && cyc == t_done + 1);
      chk("mem_ack",   mem_ack,   t_active &&  t_data && t_done >= 0 && cyc == t_done + 1);
      chk("if_instr",  if_instr,  m_if_instr);
      chk("mem_rdata", mem_rdata, m_mem_rdata);
      chk("stall_if",  stall_if,  if_req  && !(t_active && !t_data && t_done >= 0 && cyc == t_done + 1));
      chk("stall_mem", stall_mem, mem_req && !(t_active &&  t_data && t_done >= 0 && cyc == t_done + 1));
      if (if_ack)     begin n_if_ack++;  last_if_ack  = cyc; end
      if (mem_ack)    begin n_mem_ack++; last_mem_ack = cyc; end
      if (ram_rvalid) last_rvalid = cyc;
      if (ram_req) begin
        last_rr_cyc = cyc; last_rr_addr = ram_addr;
        last_rr_we = ram_we; last_rr_wdata = ram_wdata;
        rr_addr.push_back(ram_addr);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_ack(input bit is_data, input int bound, input string name);
    int start_n = is_data ? n_mem_ack : n_if_ack;
    int k = 0;
    while (((is_data ? n_mem_ack : n_if_ack) == start_n) && k < bound) begin
      tick(1); k++;
    end
    chk(name, (is_data ? n_mem_ack : n_if_ack) - start_n, 1);
  endtask

  task automatic wait_grants(input int target, input int bound);
    int k = 0;
    while (rr_addr.size() < target && k < bound) begin
      tick(1); k++;
    end
    chk("grant_timeout", (rr_addr.size() >= target), 1);
  endtask

  int g, ma, n0, ia0, rc;

  initial begin
    // Reset
    tick(3);
    reset = 1'b0;
    chk("reset_ram_addr", ram_addr, 0);
    chk("reset_if_ack", if_ack, 0);
    chk("reset_ram_req", ram_req, 0);
    tick(2);

    // Fetch only
    lat = 1; rd_val = 64'h00000000_8B020041;
    if_addr = 64'h10; if_req = 1'b1; g = cyc;
    wait_ack(1'b0, 20, "fetch_ack_timeout");
    if_req = 1'b0;
    chk("fetch_latency", last_if_ack - g, 3);
    chk("fetch_ram_req_cycle", last_rr_cyc - g, 1);
    chk("fetch_ram_addr", last_rr_addr, 64'h10);
    chk("fetch_ram_we", last_rr_we, 0);
    chk("fetch_instr", if_instr, 32'h8B020041);
    tick(2);

    // Collision: data first, fetch granted in the IDLE cycle after mem_ack
    rd_val = 64'h11223344_55667788;
    if_addr = 64'h18; mem_addr = 64'h40; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1;
    wait_ack(1'b1, 20, "coll_mem_ack_timeout");
    mem_req = 1'b0; ma = last_mem_ack;
    wait_ack(1'b0, 20, "coll_if_ack_timeout");
    if_req = 1'b0;
    chk("coll_mem_before_if", ma < last_if_ack, 1);
    chk("coll_fetch_req_cycle", last_rr_cyc - ma, 2);
    chk("coll_fetch_addr", last_rr_addr, 64'h18);
    chk("coll_mem_rdata", mem_rdata, 64'h11223344_55667788);
    tick(2);

    // Store with 3-cycle memory latency
    lat = 3; rd_val = 64'h0BAD_0BAD_0BAD_0BAD;
    mem_addr = 64'h80; mem_we = 1'b1; mem_wdata = 64'hDEADBEEF; mem_req = 1'b1;
    wait_ack(1'b1, 20, "store_ack_timeout");
    mem_req = 1'b0; mem_we = 1'b0;
    chk("store_ram_we", last_rr_we, 1);
    chk("store_ram_wdata", last_rr_wdata, 64'hDEADBEEF);
    chk("store_ram_lat", last_rvalid - last_rr_cyc, 3);
    chk("store_ack_after_rvalid", last_mem_ack - last_rvalid, 1);
    chk("store_rdata_kept", mem_rdata, 64'h11223344_55667788);
    tick(2);

    // Starvation: data held continuously with a fetch pending
    lat = 1; rd_val = 64'hA5A5A5A5_13001300;
    if_addr = 64'h20; mem_addr = 64'h100; mem_we = 1'b0;
    n0 = rr_addr.size();
    if_req = 1'b1; mem_req = 1'b1;
    wait_grants(n0 + 5, 40);
    if (rr_addr.size() >= n0 + 5) begin
      chk("starve_g1_data", rr_addr[n0],     64'h100);
      chk("starve_g4_data", rr_addr[n0 + 3], 64'h100);
      chk("starve_g5", rr_addr[n0 + 4], GUARD ? 64'h20 : 64'h100);
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_cnt_cleared", dut.u_starve.count, 0);
`endif
    mem_req = 1'b0;
    wait_ack(1'b0, 30, "starve_if_ack_timeout");
    if_req = 1'b0;
    tick(3);

    // Reset during BUSY, completion arrives after reset
    lat = 10; rd_val = 64'h77777777_77777777;
    mem_addr = 64'h200; mem_we = 1'b0; mem_req = 1'b1;
    n0 = rr_addr.size();
    wait_grants(n0 + 1, 10);
    reset = 1'b1; mem_req = 1'b0;
    tick(1);
    reset = 1'b0; rc = cyc;
    chk("rst_busy_ram_addr", ram_addr, 0);
    chk("rst_busy_mem_rdata", mem_rdata, 0);
    chk("rst_busy_if_instr", if_instr, 0);
    stray_cyc = cyc + 1;
    tick(6);
    chk("stray_rvalid_seen", last_rvalid, stray_cyc);
    chk("stray_no_mem_ack", last_mem_ack < rc, 1);
    chk("stray_no_if_ack", last_if_ack < rc, 1);
    stray_cyc = -1;

    // Dropped fetch request mid-transaction
    lat = 2; rd_val = 64'h12345678_CAFEF00D;
    if_addr = 64'h30; n0 = rr_addr.size(); ia0 = n_if_ack;
    if_req = 1'b1;
    wait_grants(n0 + 1, 10);
    if_req = 1'b0;
    wait_ack(1'b0, 20, "drop_if_ack_timeout");
    tick(6);
    chk("drop_one_ack", n_if_ack - ia0, 1);
    chk("drop_one_ram_req", rr_addr.size() - n0, 1);
    chk("drop_instr", if_instr, 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
